cache_miss_sequencer: RTL

CACHE_MISS_SEQUENCER -- requirements
Module: cache_miss_sequencer

---
 rtl/cache_miss_sequencer.sv | 96 +++++++++
 1 files changed

// File: rtl/cache_miss_sequencer.sv
// cache_miss_sequencer: turns a cache miss into an optional writeback followed by a refill read
module cache_miss_sequencer #(
   parameter int DATA_WIDTH     = 32,
   parameter int RAM_ADDR_WIDTH = 32,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      en,
   input  logic                      miss,
   input  logic                      dirty_evict,
   input  logic [RAM_ADDR_WIDTH-1:0] evict_addr,
   input  logic [DATA_WIDTH-1:0]     evict_data,
   input  logic [RAM_ADDR_WIDTH-1:0] fill_addr,
   output logic                      ram_req,
   output logic                      ram_we,
   output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0]     ram_wdata,
   input  logic                      ram_ack,
   input  logic [DATA_WIDTH-1:0]     ram_rdata,
   output logic                      stall,
   output logic                      fill_valid,
   output logic [DATA_WIDTH-1:0]     fill_data,
   output logic [CNT_WIDTH-1:0]      miss_count,
   output logic [CNT_WIDTH-1:0]      wb_count
);
   typedef enum logic [1:0] {IDLE, WB, FILL, DONE} state_t;
   localparam logic [RAM_ADDR_WIDTH-1:0] WORD_MASK = ~RAM_ADDR_WIDTH'(3);
   state_t state, state_next;
   logic [RAM_ADDR_WIDTH-1:0] cap_evict_addr, cap_fill_addr;
   logic [DATA_WIDTH-1:0] cap_evict_data;
   logic start;
   assign start = (state == IDLE) && en && miss;
   // next state and outputs; the RAM bus depends only on state and captured registers
   always_comb begin
      state_next = state;
      ram_req    = 1'b0;
      ram_we     = 1'b0;
      ram_addr   = '0;
      ram_wdata  = '0;
      fill_valid = 1'b0;
      stall      = rst_n && (start || state == WB || state == FILL);
      case (state)
         IDLE: if (start) state_next = dirty_evict ? WB : FILL;
         WB: begin
            ram_req   = 1'b1;
            ram_we    = 1'b1;
            ram_addr  = cap_evict_addr & WORD_MASK;
            ram_wdata = cap_evict_data;
            if (ram_ack) state_next = FILL;
         end
         FILL: begin
            ram_req  = 1'b1;
            ram_addr = cap_fill_addr & WORD_MASK;
            if (ram_ack) state_next = DONE;
         end
         DONE: begin
            fill_valid = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end
   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end
   // capture the miss context once, so later input churn cannot disturb the transaction
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap_evict_addr <= '0;
         cap_evict_data <= '0;
         cap_fill_addr  <= '0;
      end else if (start) begin
         cap_evict_addr <= evict_addr;
         cap_evict_data <= evict_data;
         cap_fill_addr  <= fill_addr;
      end
   end
   // refill word is held until the next refill completes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                      fill_data <= '0;
      else if (state == FILL && ram_ack) fill_data <= ram_rdata;
   end
   // saturating statistics counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         miss_count <= '0;
         wb_count   <= '0;
      end else begin
         if (state == DONE && !(&miss_count))          miss_count <= miss_count + CNT_WIDTH'(1);
         if (state == WB && ram_ack && !(&wb_count))   wb_count   <= wb_count + CNT_WIDTH'(1);
      end
   end
endmodule
